// File: rtl/wave_capture_pkg.sv
// Shared types and helpers for the wave capture buffer.
package wave_capture_pkg;

    // Capture controller states
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StCapture = 2'd2,
        StDone    = 2'd3
    } wave_state_e;

    // Width of the optional decimation control
    localparam int unsigned DECIM_W = 16;

    // Address width needed to index a buffer of the given depth
    function automatic int unsigned addr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// A read of the address being written in the same cycle returns the old data.
module capture_ram
    import wave_capture_pkg::*;
#(
    parameter int unsigned NUM_SIG  = 8,
    parameter int unsigned NUM_SAMP = 128
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_we,
    input  logic [addr_w(NUM_SAMP)-1:0] i_waddr,
    input  logic [NUM_SIG-1:0]          i_wdata,
    input  logic [addr_w(NUM_SAMP)-1:0] i_raddr,
    output logic [NUM_SIG-1:0]          o_rdata
);

    logic [NUM_SIG-1:0] r_mem [NUM_SAMP];
    logic [NUM_SIG-1:0] r_rdata;

    // Write port; contents are deliberately not reset
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port, cleared by reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/wave_capture_buffer.sv
// Triggered logic-analyser style capture buffer.
// Optional feature: define WAVE_CAPTURE_DECIM_EN to add the decim input, which
// writes one sample every decim+1 cycles during capture.
module wave_capture_buffer
    import wave_capture_pkg::*;
#(
    parameter int unsigned NUM_SIG  = 8,
    parameter int unsigned NUM_SAMP = 128
) (
    input  logic                        wave_clk,
    input  logic                        wave_reset,
    input  logic [NUM_SIG-1:0]          input_signals,
    input  logic                        arm,
    input  logic                        abort,
    input  logic [NUM_SIG-1:0]          trig_mask,
    input  logic [NUM_SIG-1:0]          trig_value,
    input  logic [addr_w(NUM_SAMP)-1:0] rd_addr,
`ifdef WAVE_CAPTURE_DECIM_EN
    input  logic [DECIM_W-1:0]          decim,
`endif
    output logic [NUM_SIG-1:0]          rd_data,
    output logic                        busy,
    output logic                        done,
    output logic [addr_w(NUM_SAMP):0]   samp_count
);

    localparam int unsigned AW = addr_w(NUM_SAMP);
    localparam int unsigned CW = AW + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_SAMP - 1);

    logic [NUM_SIG-1:0] r_sync1;
    logic [NUM_SIG-1:0] r_sync2;
    wave_state_e        r_state;
    wave_state_e        w_state_d;
    logic [CW-1:0]      r_samp_count;
    logic [CW-1:0]      w_samp_count_d;
    logic               w_we;
    logic               w_trig;
    logic               w_take;

    // Two-flop synchronizer on the asynchronous capture pins
    always_ff @(posedge wave_clk) begin
        if (wave_reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= input_signals;
            r_sync2 <= r_sync1;
        end
    end

    // Masked compare; an all-zero mask matches immediately
    assign w_trig = (((r_sync2 ^ trig_value) & trig_mask) == '0);

`ifdef WAVE_CAPTURE_DECIM_EN
    logic [DECIM_W-1:0] r_decim_cnt;
    logic [DECIM_W-1:0] w_decim_cnt_d;

    assign w_take = (r_decim_cnt == decim);

    // Decimation phase counter; held at zero outside capture so the phase
    // always starts from the trigger sample
    always_comb begin
        w_decim_cnt_d = '0;
        if (r_state == StCapture && !w_take) begin
            w_decim_cnt_d = r_decim_cnt + DECIM_W'(1);
        end
    end

    // Decimation counter register
    always_ff @(posedge wave_clk) begin
        if (wave_reset) begin
            r_decim_cnt <= '0;
        end else begin
            r_decim_cnt <= w_decim_cnt_d;
        end
    end
`else
    assign w_take = 1'b1;
`endif

    // State and sample-count registers
    always_ff @(posedge wave_clk) begin
        if (wave_reset) begin
            r_state      <= StIdle;
            r_samp_count <= '0;
        end else begin
            r_state      <= w_state_d;
            r_samp_count <= w_samp_count_d;
        end
    end

    // Next-state, write enable and sample-count update
    always_comb begin
        w_state_d      = r_state;
        w_samp_count_d = r_samp_count;
        w_we           = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (arm) begin
                    w_state_d      = StArmed;
                    w_samp_count_d = '0;
                end
            end
            StArmed: begin
                // Trigger sample lands at address 0 (count was cleared on arm)
                if (w_trig) begin
                    w_we           = 1'b1;
                    w_samp_count_d = r_samp_count + CW'(1);
                    w_state_d      = StCapture;
                end
            end
            StCapture: begin
                if (w_take) begin
                    w_we           = 1'b1;
                    w_samp_count_d = r_samp_count + CW'(1);
                    if (r_samp_count[AW-1:0] == LAST_ADDR) begin
                        w_state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (arm) begin
                    w_state_d      = StArmed;
                    w_samp_count_d = '0;
                end
            end
        endcase
        // Abort and reset win over arm and trigger; no write in that cycle
        if (abort || wave_reset) begin
            w_state_d      = StIdle;
            w_samp_count_d = r_samp_count;
            w_we           = 1'b0;
        end
    end

    capture_ram #(
        .NUM_SIG  (NUM_SIG),
        .NUM_SAMP (NUM_SAMP)
    ) u_capture_ram (
        .i_clk   (wave_clk),
        .i_rst   (wave_reset),
        .i_we    (w_we),
        .i_waddr (r_samp_count[AW-1:0]),
        .i_wdata (r_sync2),
        .i_raddr (rd_addr),
        .o_rdata (rd_data)
    );

    assign busy       = (r_state == StArmed) || (r_state == StCapture);
    assign done       = (r_state == StDone);
    assign samp_count = r_samp_count;

endmodule

// File: tb/tb_wave_capture_buffer.sv
// Self-checking bench for wave_capture_buffer (scoreboard of expected samples).
// Define WAVE_CAPTURE_DECIM_EN to also exercise decimation.
module tb_wave_capture_buffer;

    localparam int unsigned NUM_SIG  = 8;
    localparam int unsigned NUM_SAMP = 128;

    logic       wave_clk;
    logic       wave_reset;
    logic [7:0] input_signals;
    logic       arm;
    logic       abort;
    logic [7:0] trig_mask;
    logic [7:0] trig_value;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;
    logic [7:0] samp_count;
`ifdef WAVE_CAPTURE_DECIM_EN
    logic [15:0] decim;
`endif

    int n_pass;
    int n_total;
    logic [7:0] sb_q[$];

    wave_capture_buffer #(
        .NUM_SIG  (NUM_SIG),
        .NUM_SAMP (NUM_SAMP)
    ) dut (
`ifdef WAVE_CAPTURE_DECIM_EN
        .decim         (decim),
`endif
        .wave_clk      (wave_clk),
        .wave_reset    (wave_reset),
        .input_signals (input_signals),
        .arm           (arm),
        .abort         (abort),
        .trig_mask     (trig_mask),
        .trig_value    (trig_value),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .busy          (busy),
        .done          (done),
        .samp_count    (samp_count)
    );

    initial wave_clk = 1'b0;
    always #5 wave_clk = ~wave_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge
    task automatic tick();
        @(negedge wave_clk);
    endtask

    // Read one address and compare against the next scoreboard entry
    task automatic read_check(input string tag, input int addr);
        logic [7:0] exp;
        exp = 8'hxx;
        rd_addr = 7'(addr);
        tick();
        if (sb_q.size() != 0) exp = sb_q.pop_front();
        check($sformatf("%s%0d", tag, addr), {24'd0, rd_data}, {24'd0, exp});
    endtask

    // Ramp value base+m driven each cycle, m=0 one cycle before arm, so with an
    // all-zero mask the trigger sample is base. Captured values are pushed as
    // they are driven. Returns cycles after the arm edge until done.
    task automatic ramp_capture(input logic [7:0] base, input int stride, input int abort_at,
                                input int arm_mid, output int n, output int busy_bad);
        int m;
        int pushed;
        bit aborted;
        m = 0;
        pushed = 0;
        aborted = 0;
        busy_bad = 0;
        n = 0;
        input_signals = base;
        sb_q.push_back(base);
        pushed++;
        tick();
        m = 1;
        input_signals = base + 8'(m);
        arm = 1'b1;
        if (stride == 1 && (abort_at < 0 || m < abort_at)) begin
            sb_q.push_back(base + 8'(m));
            pushed++;
        end
        tick();
        arm = 1'b0;
        while (!done && !aborted && n < 2000) begin
            m++;
            input_signals = base + 8'(m);
            if ((m % stride) == 0 && pushed < int'(NUM_SAMP)
                && (abort_at < 0 || m < abort_at)) begin
                sb_q.push_back(base + 8'(m));
                pushed++;
            end
            abort = (n == abort_at);
            arm = (n == arm_mid);
            tick();
            n++;
            arm = 1'b0;
            if (abort) begin
                abort = 1'b0;
                aborted = 1;
            end else if (!done && !busy) begin
                busy_bad++;
            end
        end
    endtask

    initial begin
        int n;
        int bad;
        n_pass = 0;
        n_total = 0;
        wave_reset = 1'b1;
        input_signals = '0;
        arm = 1'b0;
        abort = 1'b0;
        trig_mask = '0;
        trig_value = '0;
        rd_addr = '0;
`ifdef WAVE_CAPTURE_DECIM_EN
        decim = 16'd0;
`endif
        repeat (3) tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_count", {24'd0, samp_count}, 32'd0);
        check("rst_rdata", {24'd0, rd_data}, 32'd0);
        wave_reset = 1'b0;
        tick();

        // Immediate trigger, full ramp capture, stray arm mid-capture ignored
        ramp_capture(8'h00, 1, -1, 60, n, bad);
        check("t1_cycles", n, 32'd128);
        check("t1_busy", bad, 32'd0);
        check("t1_done", {31'd0, done}, 32'd1);
        check("t1_busy_done", {31'd0, busy}, 32'd0);
        check("t1_count", {24'd0, samp_count}, 32'd128);
        for (int k = 0; k < int'(NUM_SAMP); k++) read_check("t1_rd", k);

        // Bit-7 trigger rising at cycle 50, re-armed from DONE
        input_signals = 8'h00;
        trig_mask = 8'h80;
        trig_value = 8'h80;
        repeat (3) tick();
        begin
            int t;
            int pushed;
            logic [7:0] v;
            t = 0;
            pushed = 0;
            bad = 0;
            while (!(t > 0 && done) && t < 600) begin
                v = (t < 50) ? (8'(t) & 8'h7F) : (8'h80 | (8'(t) & 8'h7F));
                input_signals = v;
                arm = (t == 0);
                if (t >= 50 && pushed < int'(NUM_SAMP)) begin
                    sb_q.push_back(v);
                    pushed++;
                end
                tick();
                arm = 1'b0;
                if (t == 0) check("t2_count_clr", {24'd0, samp_count}, 32'd0);
                if (!done && !busy) bad++;
                t++;
            end
        end
        check("t2_busy", bad, 32'd0);
        check("t2_done", {31'd0, done}, 32'd1);
        check("t2_count", {24'd0, samp_count}, 32'd128);
        for (int k = 0; k < int'(NUM_SAMP); k++) read_check("t2_rd", k);

        // Abort at capture sample 40
        trig_mask = 8'h00;
        ramp_capture(8'h40, 1, 40, -1, n, bad);
        check("t3_busy", {31'd0, busy}, 32'd0);
        check("t3_done", {31'd0, done}, 32'd0);
        check("t3_count", {24'd0, samp_count}, 32'd40);
        repeat (2) tick();
        check("t3_count_hold", {24'd0, samp_count}, 32'd40);
        for (int k = 0; k < 40; k++) read_check("t3_rd", k);
        // Address 40 still holds the previous capture (t=90 of the bit-7 run)
        sb_q.push_back(8'h80 | 8'd90);
        read_check("t3_keep", 40);

        // Arm and abort together from IDLE
        arm = 1'b1;
        abort = 1'b1;
        tick();
        arm = 1'b0;
        abort = 1'b0;
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_done", {31'd0, done}, 32'd0);
        check("t4_count", {24'd0, samp_count}, 32'd40);
        tick();
        check("t4_busy2", {31'd0, busy}, 32'd0);

        // Reset mid-capture
        arm = 1'b1;
        tick();
        arm = 1'b0;
        repeat (20) tick();
        check("t5_busy_pre", {31'd0, busy}, 32'd1);
        rd_addr = 7'd5;
        wave_reset = 1'b1;
        tick();
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_done", {31'd0, done}, 32'd0);
        check("t5_count", {24'd0, samp_count}, 32'd0);
        check("t5_rdata", {24'd0, rd_data}, 32'd0);
        wave_reset = 1'b0;
        tick();
        check("t5_idle", {31'd0, busy}, 32'd0);

`ifdef WAVE_CAPTURE_DECIM_EN
        // Decimation by 4: sample k is trigger value + 4k
        decim = 16'd3;
        ramp_capture(8'h10, 4, -1, -1, n, bad);
        check("t6_cycles", n, 32'((NUM_SAMP - 1) * 4 + 1));
        check("t6_busy", bad, 32'd0);
        check("t6_count", {24'd0, samp_count}, 32'd128);
        for (int k = 0; k < int'(NUM_SAMP); k++) read_check("t6_rd", k);
        decim = 16'd0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wave_capture_buffer.md
WAVE_CAPTURE_BUFFER -- requirements
Module: wave_capture_buffer

Interface
REQ-001 SHALL have parameter NUM_SIG, default 8, width of the captured bus.
REQ-002 SHALL have parameter NUM_SAMP, default 128, capture depth in samples, power of two, minimum 4.
REQ-003 SHALL have port wave_clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port wave_reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port input_signals, input, NUM_SIG, asynchronous pins to be sampled.
REQ-006 SHALL have port arm, input, 1, single-cycle pulse that starts trigger search.
REQ-007 SHALL have port abort, input, 1, single-cycle pulse that returns the block to IDLE.
REQ-008 SHALL have port trig_mask, input, NUM_SIG, bits that participate in the trigger compare.
REQ-009 SHALL have port trig_value, input, NUM_SIG, required levels on the masked bits.
REQ-010 SHALL have port rd_addr, input, log2(NUM_SAMP), sample readout address.
REQ-011 SHALL have port rd_data, output, NUM_SIG, sample at rd_addr.
REQ-012 SHALL have port busy, output, 1, high in ARMED or CAPTURE.
REQ-013 SHALL have port done, output, 1, high in DONE.
REQ-014 SHALL have port samp_count, output, log2(NUM_SAMP)+1, number of samples written.

Function
REQ-015 SHALL pass input_signals through a two-flop synchronizer; only the synchronized value (sync) is used, giving 2 cycles of input latency.
REQ-016 SHALL implement states IDLE, ARMED, CAPTURE and DONE.
REQ-017 SHALL move IDLE->ARMED on arm, clearing samp_count to 0 in the same edge.
REQ-018 SHALL move ARMED->CAPTURE on the first cycle where (sync & trig_mask) == (trig_value & trig_mask); that cycle's sample is written at address 0.
REQ-019 SHALL treat trig_mask == 0 as an immediate trigger on the first ARMED cycle.
REQ-020 SHALL, in CAPTURE, write one sample per cycle at address samp_count and increment samp_count.
REQ-021 SHALL move CAPTURE->DONE in the cycle the write at address NUM_SAMP-1 occurs; samp_count reads NUM_SAMP in DONE.
REQ-022 SHALL never wrap the write address or overwrite captured data.
REQ-023 SHALL move DONE->ARMED on arm and restart capture from address 0.
REQ-024 SHALL ignore arm while in ARMED or CAPTURE.
REQ-025 SHALL move any state to IDLE on abort, keep memory contents and samp_count, and let abort win over simultaneous arm or trigger.
REQ-026 SHALL register rd_data with 1-cycle latency from rd_addr, readable in any state; a same-address read during a write returns the old data.

Reset
REQ-027 SHALL on wave_reset enter IDLE, set samp_count=0, busy=0, done=0, rd_data=0 and synchronizer flops to 0; memory content is not reset.
REQ-028 SHALL let reset mid-capture discard the capture and override all other inputs.

Configuration
REQ-029 SHALL, with macro WAVE_CAPTURE_DECIM_EN defined, add input decim (16 bits): in CAPTURE, a sample is written every decim+1 cycles, counted from the trigger sample; decim=0 is equivalent to no decimation.
REQ-030 SHALL, without WAVE_CAPTURE_DECIM_EN, omit the decim port and the decimation counter and write one sample every cycle.

Structure
REQ-031 SHALL place the state enum and the address-width helper in package wave_capture_pkg.
REQ-032 SHALL implement storage as sub-module capture_ram: simple dual-port, one write port and one registered read port, NUM_SAMP x NUM_SIG.

Verification
REQ-033 SHALL cover the following: reset, then arm with trig_mask=0 and a ramp 0..255 on input_signals -> done after 128 capture cycles, rd_addr k returns the ramp value for k, samp_count=128.
REQ-034 SHALL cover the following: trig_mask=0x80, trig_value=0x80, bit 7 rising at cycle 50 -> rd_addr 0 holds the first sample with bit 7 set, and busy is high from arm until done.
REQ-035 SHALL cover the following: abort at capture sample 40 -> IDLE, samp_count=40, done=0, and samples 0..39 are readable and unchanged.
REQ-036 SHALL cover the following: arm and abort in the same cycle from IDLE -> state stays IDLE.
REQ-037 SHALL cover the following: wave_reset asserted mid-capture -> next cycle busy=0, done=0, samp_count=0.
REQ-038 SHALL cover the following: with WAVE_CAPTURE_DECIM_EN, decim=3 and a ramp input -> rd_addr k returns the trigger value + 4k.
